// File: rtl/clk_mon_pkg.sv
// Shared definitions for the divided-clock monitor: FSM states and default limits.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } mon_state_e;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_EXP_PERIOD  = 11;
  localparam int DEF_EXP_HIGH    = 6;
  localparam int DEF_TOL         = 1;
  localparam int DEF_LOCK_CNT    = 4;
  localparam int DEF_TIMEOUT     = 64;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_rise_det.sv
// Synchronizes an asynchronous level into clk_in and flags its rising transitions.
// The s and rise outputs are both registered and aligned: rise is high in the first cycle s reads 1.
module sync_rise_det #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic din,
  output logic s,
  output logic rise
);

  logic [STAGES-1:0] chain_r;
  logic              s_r;
  logic              rise_r;

  // Synchronizer chain followed by an aligned level/edge output stage
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      chain_r <= '0;
      s_r     <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      chain_r[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        chain_r[i] <= chain_r[i-1];
      end
      s_r    <= chain_r[STAGES-1];
      rise_r <= chain_r[STAGES-1] & ~s_r;
    end
  end

  assign s    = s_r;
  assign rise = rise_r;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock in clk_in cycles, checks them
// against expected values, and reports lock and loss-of-toggle conditions.
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int EXP_PERIOD  = DEF_EXP_PERIOD,
  parameter int EXP_HIGH    = DEF_EXP_HIGH,
  parameter int TOL         = DEF_TOL,
  parameter int LOCK_CNT    = DEF_LOCK_CNT,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             div_clk,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             mis_pulse,
  output logic             locked,
  output logic             timeout
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] EXP_P_C   = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] EXP_H_C   = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
  localparam logic [MW-1:0]    LOCK_C    = MW'(LOCK_CNT);
  localparam logic [IW-1:0]    TIMEOUT_C = IW'(TIMEOUT);

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    if (a >= b) begin
      abs_diff = a - b;
    end else begin
      abs_diff = b - a;
    end
  endfunction

  mon_state_e       state_r, state_nxt;
  logic [CNT_W-1:0] pcnt_r, pcnt_nxt, hcnt_r, hcnt_nxt;
  logic [CNT_W-1:0] period_r, period_nxt, high_r, high_nxt;
  logic [IW-1:0]    idle_r, idle_nxt, idle_inc_s;
  logic [MW-1:0]    match_r, match_nxt, match_inc_s;
  logic             mv_r, mv_nxt, mis_r, mis_nxt;
  logic             locked_r, locked_nxt, timeout_r, timeout_nxt;
  logic             samp_s, rise_s, good_s, idle_hit_s;
  logic [CNT_W-1:0] pcnt_inc_s, hcnt_inc_s;

  sync_rise_det #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .din    (div_clk),
    .s      (samp_s),
    .rise   (rise_s)
  );

  assign pcnt_inc_s  = (pcnt_r == CNT_MAX) ? pcnt_r : pcnt_r + CNT_ONE;
  assign hcnt_inc_s  = (hcnt_r == CNT_MAX) ? hcnt_r : hcnt_r + CNT_ONE;
  assign idle_inc_s  = idle_r + IW'(1);
  assign idle_hit_s  = (idle_inc_s == TIMEOUT_C);
  assign match_inc_s = (match_r == LOCK_C) ? match_r : match_r + MW'(1);
  assign good_s      = (abs_diff(pcnt_r, EXP_P_C) <= TOL_C) &&
                       (abs_diff(hcnt_r, EXP_H_C) <= TOL_C);

  // Next-state and datapath decisions; en low overrides everything
  always_comb begin
    state_nxt   = state_r;
    pcnt_nxt    = pcnt_r;
    hcnt_nxt    = hcnt_r;
    idle_nxt    = idle_r;
    match_nxt   = match_r;
    period_nxt  = period_r;
    high_nxt    = high_r;
    mv_nxt      = 1'b0;
    mis_nxt     = 1'b0;
    locked_nxt  = locked_r;
    timeout_nxt = timeout_r;

    case (state_r)
      ST_IDLE: begin
        locked_nxt  = 1'b0;
        timeout_nxt = 1'b0;
        match_nxt   = '0;
        idle_nxt    = '0;
        if (en) begin
          state_nxt = ST_ARM;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (rise_s) begin
          pcnt_nxt    = CNT_ONE;
          hcnt_nxt    = CNT_ONE;
          idle_nxt    = '0;
          timeout_nxt = 1'b0;
          state_nxt   = ST_MEAS;
        end else if (idle_hit_s) begin
          timeout_nxt = 1'b1;
          locked_nxt  = 1'b0;
          match_nxt   = '0;
          idle_nxt    = '0;
          state_nxt   = ST_ARM;
        end else begin
          idle_nxt = idle_inc_s;
        end
      end
      ST_MEAS: begin
        if (rise_s) begin
          period_nxt  = pcnt_r;
          high_nxt    = hcnt_r;
          mv_nxt      = 1'b1;
          pcnt_nxt    = CNT_ONE;
          hcnt_nxt    = CNT_ONE;
          idle_nxt    = '0;
          timeout_nxt = 1'b0;
          if (good_s) begin
            match_nxt  = match_inc_s;
            locked_nxt = (match_inc_s == LOCK_C);
          end else begin
            mis_nxt    = 1'b1;
            match_nxt  = '0;
            locked_nxt = 1'b0;
          end
        end else if (idle_hit_s) begin
          timeout_nxt = 1'b1;
          locked_nxt  = 1'b0;
          match_nxt   = '0;
          idle_nxt    = '0;
          state_nxt   = ST_ARM;
        end else begin
          pcnt_nxt = pcnt_inc_s;
          idle_nxt = idle_inc_s;
          if (samp_s) begin
            hcnt_nxt = hcnt_inc_s;
          end else begin
            hcnt_nxt = hcnt_r;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (!en) begin
      state_nxt   = ST_IDLE;
      pcnt_nxt    = pcnt_r;
      hcnt_nxt    = hcnt_r;
      period_nxt  = period_r;
      high_nxt    = high_r;
      mv_nxt      = 1'b0;
      mis_nxt     = 1'b0;
      locked_nxt  = 1'b0;
      timeout_nxt = 1'b0;
      match_nxt   = '0;
      idle_nxt    = '0;
    end else begin
      state_nxt = state_nxt;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      pcnt_r    <= '0;
      hcnt_r    <= '0;
      idle_r    <= '0;
      match_r   <= '0;
      period_r  <= '0;
      high_r    <= '0;
      mv_r      <= 1'b0;
      mis_r     <= 1'b0;
      locked_r  <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      pcnt_r    <= pcnt_nxt;
      hcnt_r    <= hcnt_nxt;
      idle_r    <= idle_nxt;
      match_r   <= match_nxt;
      period_r  <= period_nxt;
      high_r    <= high_nxt;
      mv_r      <= mv_nxt;
      mis_r     <= mis_nxt;
      locked_r  <= locked_nxt;
      timeout_r <= timeout_nxt;
    end
  end

  assign period     = period_r;
  assign high_time  = high_r;
  assign meas_valid = mv_r;
  assign mis_pulse  = mis_r;
  assign locked     = locked_r;
  assign timeout    = timeout_r;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Drives directed and random div_clk waveforms into two monitors (CNT_W 8 and 4) and
// checks every cycle against a timestamp-based reference model.
module tb_clk_div_monitor;

  localparam int LAT   = 3;    // sync depth + 1: driven edge to FSM decision
  localparam int TMO   = 64;
  localparam int LOCKN = 4;

  logic       clk_in = 1'b0;
  logic       rst, en, div_clk;
  logic [7:0] period8, high8;
  logic [3:0] period4, high4;
  logic       mv8, mis8, lk8, to8, mv4, mis4, lk4, to4;

  always #5 clk_in = ~clk_in;

  clk_div_monitor u_dut8 (
    .clk_in(clk_in), .rst(rst), .en(en), .div_clk(div_clk),
    .period(period8), .high_time(high8), .meas_valid(mv8),
    .mis_pulse(mis8), .locked(lk8), .timeout(to8)
  );

  clk_div_monitor #(.CNT_W(4)) u_dut4 (
    .clk_in(clk_in), .rst(rst), .en(en), .div_clk(div_clk),
    .period(period4), .high_time(high4), .meas_valid(mv4),
    .mis_pulse(mis4), .locked(lk4), .timeout(to4)
  );

  int checks = 0;
  int failures = 0;
  int p = 0;
  int p0 = 0;
  bit hist [0:8191];
  bit enh;

  // Reference model: mode 0 idle, 1 waiting for first edge, 2 measuring
  int m_mode[2], m_anchor[2], m_last[2], m_streak[2], m_per[2], m_hi[2];
  bit m_mv[2], m_mis[2], m_lk[2], m_to[2];

  function automatic int dval(int t);
    if (t < p0 || t < 0) return 0;
    return int'(hist[t]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_anchor[k] = 0; m_last[k] = 0; m_streak[k] = 0;
      m_per[k] = 0; m_hi[k] = 0; m_mv[k] = 0; m_mis[k] = 0; m_lk[k] = 0; m_to[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int mx;
      int cnt;
      bit r;
      mx = (k == 0) ? 255 : 15;
      r = (dval(p - LAT) == 1) && (dval(p - LAT - 1) == 0);
      m_mv[k] = 0;
      m_mis[k] = 0;
      if (!enh) begin
        m_mode[k] = 0; m_lk[k] = 0; m_to[k] = 0; m_streak[k] = 0;
      end else if (m_mode[k] == 0) begin
        m_mode[k] = 1; m_anchor[k] = p;
      end else if (r) begin
        if (m_mode[k] == 2) begin
          cnt = 0;
          for (int q = m_last[k]; q < p; q++) cnt += dval(q - LAT);
          m_per[k] = (p - m_last[k] > mx) ? mx : p - m_last[k];
          m_hi[k] = (cnt > mx) ? mx : cnt;
          m_mv[k] = 1;
          if (m_per[k] >= 10 && m_per[k] <= 12 && m_hi[k] >= 5 && m_hi[k] <= 7) begin
            m_streak[k] = (m_streak[k] < LOCKN) ? m_streak[k] + 1 : LOCKN;
            m_lk[k] = (m_streak[k] == LOCKN);
          end else begin
            m_mis[k] = 1; m_streak[k] = 0; m_lk[k] = 0;
          end
        end
        m_mode[k] = 2; m_last[k] = p; m_anchor[k] = p; m_to[k] = 0;
      end else if (p - m_anchor[k] == TMO) begin
        m_to[k] = 1; m_lk[k] = 0; m_streak[k] = 0; m_mode[k] = 1; m_anchor[k] = p;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, p, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("period8", 32'(period8), 32'(m_per[0]));
    chk("high8", 32'(high8), 32'(m_hi[0]));
    chk("meas_valid8", 32'(mv8), 32'(m_mv[0]));
    chk("mis_pulse8", 32'(mis8), 32'(m_mis[0]));
    chk("locked8", 32'(lk8), 32'(m_lk[0]));
    chk("timeout8", 32'(to8), 32'(m_to[0]));
    chk("period4", 32'(period4), 32'(m_per[1]));
    chk("high4", 32'(high4), 32'(m_hi[1]));
    chk("meas_valid4", 32'(mv4), 32'(m_mv[1]));
    chk("mis_pulse4", 32'(mis4), 32'(m_mis[1]));
    chk("locked4", 32'(lk4), 32'(m_lk[1]));
    chk("timeout4", 32'(to4), 32'(m_to[1]));
  endtask

  task automatic step(input bit dv, input bit ev);
    div_clk = dv;
    en = ev;
    enh = ev;
    hist[p + 1] = dv;
    @(posedge clk_in);
    p++;
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive_period(input int hi, input int lo, input int drop_at);
    for (int i = 0; i < hi + lo; i++) begin
      step(i < hi, !(drop_at >= 0 && i >= drop_at && i < drop_at + 3));
    end
  endtask

  task automatic ideal(input int n);
    for (int i = 0; i < n; i++) begin
      int h;
      h = int'($urandom_range(5, 6));
      drive_period(h, 11 - h, -1);
    end
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk_in);
    p++;
    #1;
    check_all();
    rst = 1'b0;
    p0 = p + 1;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    div_clk = 1'b0;
    enh = 1'b0;
    model_reset();
    @(posedge clk_in);
    p++;
    #1;
    check_all();
    rst = 1'b0;
    p0 = p + 1;

    // Lock on an ideal divided clock
    ideal(6);
    // One stretched period breaks lock, then relock
    drive_period(6, 7, -1);
    ideal(5);
    // Stop toggling: timeout, then restart
    for (int i = 0; i < 80; i++) step(1'b0, 1'b1);
    ideal(5);
    // Asynchronous reset in the middle of a high phase
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    do_reset();
    ideal(6);
    // Enable dropped across a detected rise
    drive_period(6, 5, LAT);
    ideal(5);
    // Long period: saturates the narrow instance
    for (int i = 0; i < 3; i++) drive_period(10, 10, -1);
    ideal(5);
    // Random waveforms, enable glitches and gaps around the timeout limit
    for (int n = 0; n < 60; n++) begin
      int h;
      int l;
      int drop;
      h = int'($urandom_range(2, 9));
      l = int'($urandom_range(2, 9));
      drop = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 10)) : -1;
      if ($urandom_range(0, 2) == 0) begin
        ideal(1);
      end else begin
        drive_period(h, l, drop);
      end
      if ($urandom_range(0, 14) == 0) begin
        int gap;
        gap = int'($urandom_range(60, 70));
        for (int i = 0; i < gap; i++) step(1'b0, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
